fake_trigger_hls_deadlock_watchdog: RTL and testbench

Parametrised successor to the per-instance deadlock monitor for the fake_trigger HLS core. It ORs N_AXIS stream-block flags with the instance block flags and keeps the existing 1-cycle registered `block` output. Added behaviour:
- `block` can be qualified by instance idle.
- Persistence filter: only a block held for a programmable number of consecutive cycles declares a deadlock.
- Sticky latch with software clear.
- Snapshot of which AXIS channels were stalled.
- Saturating count of deadlock events.

---
 rtl/fake_trigger_dbg_pkg.sv | 25 ++
 rtl/fake_trigger_sat_counter.sv | 46 ++++
 rtl/fake_trigger_hls_deadlock_watchdog.sv | 138 +++++++++++++
 tb/tb_fake_trigger_hls_deadlock_watchdog.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fake_trigger_dbg_pkg.sv
// -----------------------------------------------------------------------------
// fake_trigger_dbg_pkg
// Shared definitions for the fake_trigger HLS debug/watchdog logic:
//   state_t        - deadlock watchdog state encoding
//   CNT_W_DEFAULT  - default width of run/threshold/event counters
//   sat_inc        - saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package fake_trigger_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        DEADLOCK = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEFAULT = 16;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fake_trigger_sat_counter.sv
// -----------------------------------------------------------------------------
// fake_trigger_sat_counter
// Saturating up-counter with synchronous clear.
//   clock, reset : core clock, synchronous active-high reset
//   inc          : increment by one (holds at all-ones)
//   clr          : synchronous clear to zero, priority over inc
//   value        : current count
//   saturated    : count is at all-ones
// -----------------------------------------------------------------------------
module fake_trigger_sat_counter
    import fake_trigger_dbg_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value,
    output logic             saturated
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = CNT_W'(sat_inc(32'(value_q), CNT_W));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value     = value_q;
    assign saturated = &value_q;

endmodule

// File: rtl/fake_trigger_hls_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// fake_trigger_hls_deadlock_watchdog
// Deadlock monitor for the fake_trigger HLS core. Any AXIS channel block or any
// non-idle instance block forms the raw block condition; a run of thr_eff
// consecutive block cycles declares a deadlock.
//   clock, reset     : core clock, synchronous active-high reset
//   axis_block_sigs  : per-channel AXIS blocked flags
//   inst_idle_sigs   : per-instance idle flags (idle masks that instance's block)
//   inst_block_sigs  : per-instance blocked flags
//   threshold        : consecutive block cycles to declare deadlock (0 -> 1)
//   clear            : clears deadlock latch, mask and state (event count kept)
//   block            : raw block condition, registered
//   deadlock         : filtered deadlock flag (sticky when STICKY=1)
//   blocked_mask     : axis_block_sigs captured on deadlock entry
//   event_count      : saturating count of deadlock entries
// -----------------------------------------------------------------------------
module fake_trigger_hls_deadlock_watchdog
    import fake_trigger_dbg_pkg::*;
#(
    parameter int unsigned N_AXIS = 5,
    parameter int unsigned N_INST = 1,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter bit          STICKY = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              clear,
    output logic              block,
    output logic              deadlock,
    output logic [N_AXIS-1:0] blocked_mask,
    output logic [CNT_W-1:0]  event_count
);

    logic              pp_block;
    logic [CNT_W-1:0]  thr_eff;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_sat;
    logic              ev_sat;
    logic              reach;
    logic              entry;

    state_t            state_q, state_d;
    logic              block_q, block_d;
    logic              deadlock_q, deadlock_d;
    logic [N_AXIS-1:0] mask_q, mask_d;

    always_comb begin
        pp_block = (|axis_block_sigs) | (|(inst_block_sigs & ~inst_idle_sigs));
        thr_eff  = (threshold == '0) ? CNT_W'(1) : threshold;
        // Compare one bit wider so a saturated run still reaches any threshold.
        reach    = ({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, thr_eff};
    end

    // Run length of consecutive pp_block cycles.
    fake_trigger_sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (pp_block & ~cnt_sat),
        .clr       (clear | ~pp_block),
        .value     (cnt),
        .saturated (cnt_sat)
    );

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pp_block) begin
                        state_d = (thr_eff == CNT_W'(1)) ? DEADLOCK : COUNT;
                    end
                end
                COUNT: begin
                    if (!pp_block) begin
                        state_d = IDLE;
                    end else if (reach) begin
                        state_d = DEADLOCK;
                    end
                end
                DEADLOCK: begin
                    if (!STICKY && !pp_block) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        entry      = (state_d == DEADLOCK) && (state_q != DEADLOCK);
        block_d    = pp_block;
        deadlock_d = (state_d == DEADLOCK);

        mask_d = mask_q;
        if (clear) begin
            mask_d = '0;
        end else if (entry) begin
            mask_d = axis_block_sigs;
        end
    end

    fake_trigger_sat_counter #(
        .CNT_W (CNT_W)
    ) u_event_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (entry & ~ev_sat),
        .clr       (1'b0),
        .value     (event_count),
        .saturated (ev_sat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            block_q    <= 1'b0;
            deadlock_q <= 1'b0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            block_q    <= block_d;
            deadlock_q <= deadlock_d;
            mask_q     <= mask_d;
        end
    end

    assign block        = block_q;
    assign deadlock     = deadlock_q;
    assign blocked_mask = mask_q;

endmodule

// File: tb/tb_fake_trigger_hls_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// Bench for fake_trigger_hls_deadlock_watchdog. Three instances share stimulus:
//   0: STICKY=1, CNT_W=16   1: STICKY=0, CNT_W=16   2: STICKY=0, CNT_W=2
// A run-length reference model tracks every instance cycle by cycle.
// -----------------------------------------------------------------------------
module tb_fake_trigger_hls_deadlock_watchdog;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [4:0]  axis  = '0;
    logic        inst_idle  = 1'b0;
    logic        inst_block = 1'b0;
    logic [15:0] thr   = 16'd4;
    logic [1:0]  thr_c;

    logic [2:0]  o_block;
    logic [2:0]  o_dl;
    logic [4:0]  o_mask [3];
    logic [15:0] o_ev   [3];
    logic [15:0] ev_a, ev_b;
    logic [1:0]  ev_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_block;
    bit         m_dl   [3];
    int         m_run  [3];
    logic [4:0] m_mask [3];
    int         m_ev   [3];

    always #5 clock = ~clock;

    always_comb begin
        thr_c   = thr[1:0];
        o_ev[0] = ev_a;
        o_ev[1] = ev_b;
        o_ev[2] = {14'd0, ev_c};
    end

    fake_trigger_hls_deadlock_watchdog #(
        .N_AXIS(5), .N_INST(1), .CNT_W(16), .STICKY(1'b1)
    ) dut_s (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_block),
        .threshold(thr), .clear(clear), .block(o_block[0]),
        .deadlock(o_dl[0]), .blocked_mask(o_mask[0]), .event_count(ev_a)
    );

    fake_trigger_hls_deadlock_watchdog #(
        .N_AXIS(5), .N_INST(1), .CNT_W(16), .STICKY(1'b0)
    ) dut_n (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_block),
        .threshold(thr), .clear(clear), .block(o_block[1]),
        .deadlock(o_dl[1]), .blocked_mask(o_mask[1]), .event_count(ev_b)
    );

    fake_trigger_hls_deadlock_watchdog #(
        .N_AXIS(5), .N_INST(1), .CNT_W(2), .STICKY(1'b0)
    ) dut_c (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_block),
        .threshold(thr_c), .clear(clear), .block(o_block[2]),
        .deadlock(o_dl[2]), .blocked_mask(o_mask[2]), .event_count(ev_c)
    );

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        bit pp;
        int te;
        @(posedge clock);
        pp = (axis != 5'd0) || (inst_block && !inst_idle);
        if (reset) begin
            m_block = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_dl[i] = 1'b0; m_run[i] = 0; m_mask[i] = '0; m_ev[i] = 0;
            end
        end else begin
            m_block = pp;
            for (int i = 0; i < 3; i++) begin
                te = (i == 2) ? int'(thr[1:0]) : int'(thr);
                if (te == 0) te = 1;
                if (clear) begin
                    m_dl[i] = 1'b0; m_run[i] = 0; m_mask[i] = '0;
                end else begin
                    m_run[i] = pp ? m_run[i] + 1 : 0;
                    if (!m_dl[i]) begin
                        if (pp && m_run[i] >= te) begin
                            m_dl[i]   = 1'b1;
                            m_mask[i] = axis;
                            if (m_ev[i] < ((i == 2) ? 3 : 65535)) m_ev[i]++;
                        end
                    end else if (i != 0 && !pp) begin
                        m_dl[i] = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [26:0] obs;
        reset = 1'b1; axis = '0; inst_idle = 0; inst_block = 0; clear = 0; thr = 16'd4;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                obs = {o_block[i], o_dl[i], o_mask[i], o_ev[i], 4'd0};
                n_checks++;
                if (obs !== 27'd0) begin
                    n_fail++;
                    $display("FAIL reset_state dut%0d cyc%0d: got blk=%b dl=%b mask=%b ev=%0d, want all 0",
                             i, k, o_block[i], o_dl[i], o_mask[i], o_ev[i]);
                end
            end
        end
    endtask

    task automatic test_persist();
        thr = 16'd4; axis = 5'b00100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (o_block[i] !== 1'b1 || o_dl[i] !== (k >= 4)) begin
                    n_fail++;
                    $display("FAIL persist dut%0d cyc%0d: got blk=%b dl=%b, want blk=1 dl=%b",
                             i, k, o_block[i], o_dl[i], k >= 4);
                end
            end
        end
        n_checks++;
        if (o_mask[0] !== 5'b00100 || o_ev[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL persist_capture: got mask=%b ev=%0d, want mask=00100 ev=1", o_mask[0], o_ev[0]);
        end
    endtask

    task automatic test_short_block();
        axis = '0; clear = 1'b1; tick(); clear = 1'b0; tick();
        axis = 5'b00001;
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) axis = '0;
            tick();
            n_checks++;
            if (o_dl[0] !== 1'b0 || o_block[0] !== (k <= 3)) begin
                n_fail++;
                $display("FAIL short_block cyc%0d: got blk=%b dl=%b, want blk=%b dl=0",
                         k, o_block[0], o_dl[0], k <= 3);
            end
        end
        n_checks++;
        if (o_ev[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL short_block_events: got %0d want 1", o_ev[0]);
        end
        inst_block = 1'b1; inst_idle = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (o_block !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_masks_block cyc%0d: got %b want 000", k, o_block);
            end
        end
        inst_idle = 1'b0;
        tick();
        n_checks++;
        if (o_block !== 3'b111) begin
            n_fail++;
            $display("FAIL inst_block: got %b want 111", o_block);
        end
        inst_block = 1'b0; tick();
    endtask

    task automatic test_sticky_clear();
        thr = 16'd4; axis = 5'b10010;
        repeat (5) tick();
        axis = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (o_dl[0] !== 1'b1 || o_dl[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL sticky_hold cyc%0d: got s=%b n=%b, want s=1 n=0", k, o_dl[0], o_dl[1]);
            end
        end
        clear = 1'b1; tick(); clear = 1'b0;
        n_checks++;
        if (o_dl[0] !== 1'b0 || o_mask[0] !== 5'd0 || o_ev[0] !== 16'd2) begin
            n_fail++;
            $display("FAIL clear: got dl=%b mask=%b ev=%0d, want dl=0 mask=00000 ev=2",
                     o_dl[0], o_mask[0], o_ev[0]);
        end
        axis = 5'b00010; clear = 1'b1; tick(); clear = 1'b0;
        n_checks++;
        if (o_dl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_priority: got dl=%b want 0", o_dl[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (o_dl[0] !== (k >= 4)) begin
                n_fail++;
                $display("FAIL restart_after_clear cyc%0d: got dl=%b want %b", k, o_dl[0], k >= 4);
            end
        end
        n_checks++;
        if (o_mask[0] !== 5'b00010 || o_ev[0] !== 16'd3) begin
            n_fail++;
            $display("FAIL restart_capture: got mask=%b ev=%0d, want 00010 ev=3", o_mask[0], o_ev[0]);
        end
        axis = '0;
    endtask

    task automatic nonsticky_bursts(input int n);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 4; k++) begin
                axis = (k < 2) ? 5'($urandom_range(1, 31)) : 5'd0;
                tick();
                n_checks++;
                if (o_dl[1] !== (k < 2) || o_block[1] !== (k < 2)) begin
                    n_fail++;
                    $display("FAIL nonsticky_follow burst%0d cyc%0d: got dl=%b blk=%b want %b",
                             b, k, o_dl[1], o_block[1], k < 2);
                end
            end
        end
    endtask

    task automatic test_nonsticky();
        reset = 1'b1; axis = '0; tick(); tick(); reset = 1'b0; tick();
        thr = 16'd0;
        nonsticky_bursts(3);
        n_checks++;
        if (o_ev[1] !== 16'd3 || o_ev[2] !== 16'd3 || o_ev[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL nonsticky_events: got s=%0d n=%0d c=%0d, want 1 3 3", o_ev[0], o_ev[1], o_ev[2]);
        end
    endtask

    task automatic test_saturate();
        nonsticky_bursts(2);
        n_checks++;
        if (o_ev[2] !== 16'd3 || o_ev[1] !== 16'd5) begin
            n_fail++;
            $display("FAIL event_saturate: got c=%0d n=%0d, want c=3 n=5", o_ev[2], o_ev[1]);
        end
        axis = '0; clear = 1'b1; tick(); clear = 1'b0;
        thr = 16'd10; axis = 5'b01000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (o_dl[0] !== 1'b0 || o_dl[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL thr10_wait cyc%0d: got s=%b n=%b want 0 0", k, o_dl[0], o_dl[1]);
            end
        end
        thr = 16'd2;
        tick();
        n_checks++;
        if (o_dl[0] !== 1'b1 || o_dl[1] !== 1'b1 || o_mask[0] !== 5'b01000) begin
            n_fail++;
            $display("FAIL thr_lowered: got s=%b n=%b mask=%b, want 1 1 01000", o_dl[0], o_dl[1], o_mask[0]);
        end
        axis = '0;
    endtask

    task automatic test_random();
        bit busy = 1'b0;
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            clear = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) thr = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) busy = !busy;
            axis = busy ? 5'($urandom_range(1, 31)) : 5'd0;
            if (!busy && $urandom_range(0, 7) == 0) axis = 5'($urandom_range(1, 31));
            inst_idle  = 1'($urandom_range(0, 1));
            inst_block = 1'($urandom_range(0, 1));
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (o_block[i] !== m_block || o_dl[i] !== m_dl[i] ||
                    o_mask[i] !== m_mask[i] || int'(o_ev[i]) != m_ev[i]) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got blk=%b dl=%b mask=%b ev=%0d, want blk=%b dl=%b mask=%b ev=%0d",
                             i, c, o_block[i], o_dl[i], o_mask[i], o_ev[i],
                             m_block, m_dl[i], m_mask[i], m_ev[i]);
                end
            end
        end
        reset = 1'b0; clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_persist();
        test_short_block();
        test_sticky_clear();
        test_nonsticky();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
